grant_arbiter: RTL and testbench

Round-robin arbiter that shares one single-owner resource between `NUM_REQ` requesters. It grants ownership until the owner signals completion, drops its request, or hits a hold-time limit. It sits between requester agents and a shared datapath unit, and drives that unit's select mux through the one-hot and index grant outputs.

---
 rtl/grant_arbiter_pkg.sv | 14 +
 rtl/param_decoder.sv | 15 +
 rtl/priority_encoder_1.sv | 19 +
 rtl/grant_arbiter.sv | 117 +++++++++++
 tb/tb_grant_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/grant_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package grant_arbiter_pkg;

    typedef enum logic {
        StIdle,
        StBusy
    } arb_state_e;

    // Mask with every bit strictly below idx set; callers slice to their width.
    function automatic logic [31:0] below_mask(input int unsigned idx);
        return (32'd1 << idx) - 32'd1;
    endfunction

endpackage

// File: rtl/param_decoder.sv
// Binary-to-one-hot decoder with enable; all zeros when disabled.
module param_decoder #(
    parameter int unsigned IN_WIDTH = 2
) (
    input  logic [IN_WIDTH-1:0]        sel,
    input  logic                       en,
    output logic [(1<<IN_WIDTH)-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/priority_encoder_1.sv
// Highest-set-bit priority encoder.
module priority_encoder_1 #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned OUT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [OUT_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = |vec;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) idx = OUT_W'(i);
        end
    end

endmodule

// File: rtl/grant_arbiter.sv
// Round-robin single-owner arbiter with done/drop/hold-limit release and registered outputs.
module grant_arbiter
    import grant_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IDX_W    = $clog2(NUM_REQ),
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               timeout
);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   timeout_q, timeout_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;

    logic [31:0]            mask_full;
    logic [NUM_REQ-1:0]     masked;
    logic [IDX_W-1:0]       masked_win, full_win, winner;
    logic                   masked_any, req_any;
    logic                   busy, at_limit, release_ev, arb_cycle, issue;
    logic [(1<<IDX_W)-1:0]  dec_out;

    assign mask_full = below_mask(32'(ptr_q));
    assign masked    = req & mask_full[NUM_REQ-1:0];

    priority_encoder_1 #(
        .WIDTH (NUM_REQ),
        .OUT_W (IDX_W)
    ) u_enc_masked (
        .vec   (masked),
        .idx   (masked_win),
        .valid (masked_any)
    );

    priority_encoder_1 #(
        .WIDTH (NUM_REQ),
        .OUT_W (IDX_W)
    ) u_enc_full (
        .vec   (req),
        .idx   (full_win),
        .valid (req_any)
    );

    assign winner     = masked_any ? masked_win : full_win;
    assign busy       = (state_q == StBusy);
    assign at_limit   = (hold_q == HOLD_W'(MAX_HOLD));
    assign release_ev = busy && (done || !req[idx_q] || at_limit);
    assign arb_cycle  = !busy || release_ev;
    assign issue      = arb_cycle && en && req_any;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        // done and a dropped request both outrank the hold limit as release causes
        timeout_d = busy && !done && req[idx_q] && at_limit;
        if (issue) begin
            state_d = StBusy;
            idx_d   = winner;
            ptr_d   = winner;
            hold_d  = HOLD_W'(1);
        end else if (release_ev) begin
            state_d = StIdle;
            idx_d   = '0;
            hold_d  = '0;
        end else if (busy) begin
            hold_d  = hold_q + HOLD_W'(1);
        end
    end

    param_decoder #(
        .IN_WIDTH (IDX_W)
    ) u_dec (
        .sel    (idx_d),
        .en     (state_d == StBusy),
        .onehot (dec_out)
    );

    assign gnt_d = dec_out[NUM_REQ-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
            gnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
            gnt_q     <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = busy;
    assign gnt_idx   = idx_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_grant_arbiter.sv
// Self-checking bench for grant_arbiter: directed scenarios plus a randomized run vs. a rule model.
module tb_grant_arbiter;

    localparam int NR    = 4;
    localparam int MH    = 16;
    localparam int BOUND = (NR - 1) * MH + NR;

    logic          clk = 1'b0;
    logic          reset, en, done;
    logic [NR-1:0] req;
    logic [NR-1:0] gnt;
    logic          gnt_valid;
    logic [1:0]    gnt_idx;
    logic          timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: owner is -1 when nobody holds the resource.
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_hold  = 0;
    bit            m_to    = 1'b0;
    logic [NR-1:0] prev_req = '0;
    bit            starve_on = 1'b0;
    int            waitc [NR];

    grant_arbiter #(
        .NUM_REQ  (NR),
        .MAX_HOLD (MH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Round-robin pick: search downward from ptr-1, wrapping, ptr itself last.
    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (p - k + NR) % NR;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic step();
        logic [NR-1:0] rq;
        bit            busy, lim, rel;
        int            n_owner, n_ptr, n_hold, w;
        bit            n_to;
        logic [31:0]   exp_gnt;
        int            worst;
        rq      = req;
        busy    = (m_owner >= 0);
        lim     = busy && (m_hold == MH);
        rel     = busy && (done || !rq[m_owner] || lim);
        n_owner = m_owner;
        n_ptr   = m_ptr;
        n_hold  = m_hold;
        n_to    = 1'b0;
        if (reset) begin
            n_owner = -1;
            n_ptr   = 0;
            n_hold  = 0;
        end else begin
            n_to = busy && !done && rq[m_owner] && lim;
            w    = pick(rq, m_ptr);
            if ((!busy || rel) && en && w >= 0) begin
                n_owner = w;
                n_ptr   = w;
                n_hold  = 1;
            end else if (rel) begin
                n_owner = -1;
                n_hold  = 0;
            end else if (busy) begin
                n_hold = m_hold + 1;
            end
        end
        @(posedge clk);
        #1;
        m_owner = n_owner;
        m_ptr   = n_ptr;
        m_hold  = n_hold;
        m_to    = n_to;
        exp_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        check("gnt", 32'(gnt), exp_gnt);
        check("gnt_idx", 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check("timeout", 32'(timeout), 32'(m_to));
        check("onehot0", 32'($onehot0(gnt)), 32'd1);
        check("valid_vs_gnt", 32'(gnt_valid), 32'(gnt != '0));
        check("idx_vs_gnt", 32'(gnt), gnt_valid ? (32'd1 << gnt_idx) : 32'd0);
        check("no_req_grant", 32'(gnt & ~rq), 32'd0);
        prev_req = rq;
        if (starve_on) begin
            worst = 0;
            for (int i = 0; i < NR; i++) begin
                if (rq[i] && !gnt[i]) waitc[i]++;
                else waitc[i] = 0;
                if (waitc[i] > worst) worst = waitc[i];
            end
            check("starvation", 32'(worst > BOUND), 32'd0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int exp_seq [5];
        reset = 1'b1;
        en    = 1'b1;
        done  = 1'b0;
        req   = '0;
        step();
        step();
        reset = 1'b0;
        step();
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_idx", 32'(gnt_idx), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);

        // Reset priority favours the MSB, then rotates below the last owner
        req = 4'b1010;
        step();
        check("first_gnt", 32'(gnt), 32'h8);
        check("first_idx", 32'(gnt_idx), 32'd3);
        done = 1'b1;
        step();
        done = 1'b0;
        check("second_gnt", 32'(gnt), 32'h2);
        check("second_idx", 32'(gnt_idx), 32'd1);

        // Rotation with done every second cycle
        do_reset();
        req = 4'b1111;
        step();
        check("rot_start", 32'(gnt_idx), 32'd3);
        exp_seq = '{3, 2, 1, 0, 3};
        for (int k = 0; k < 4; k++) begin
            step();
            check("rot_hold", 32'(gnt_idx), 32'(exp_seq[k]));
            done = 1'b1;
            step();
            done = 1'b0;
            check("rot_next", 32'(gnt_idx), 32'(exp_seq[k+1]));
            check("rot_valid", 32'(gnt_valid), 32'd1);
        end

        // Hold limit: sole requester force-released after MH cycles and re-granted
        do_reset();
        req = 4'b0100;
        step();
        for (int c = 2; c <= MH; c++) begin
            step();
            check("hold_gnt", 32'(gnt), 32'h4);
            check("hold_no_to", 32'(timeout), 32'd0);
        end
        step();
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_regrant", 32'(gnt), 32'h4);
        step();
        check("to_clear", 32'(timeout), 32'd0);
        for (int c = 3; c <= MH; c++) step();
        done = 1'b1;
        step();
        done = 1'b0;
        check("done_at_limit_no_to", 32'(timeout), 32'd0);
        check("done_at_limit_gnt", 32'(gnt), 32'h4);

        // Request drop while disabled, then enable
        do_reset();
        req = 4'b0010;
        step();
        check("drop_own", 32'(gnt_idx), 32'd1);
        en  = 1'b0;
        req = 4'b0000;
        step();
        check("drop_idle", 32'(gnt), 32'd0);
        req = 4'b0001;
        step();
        check("en_low_blocks", 32'(gnt), 32'd0);
        en = 1'b1;
        step();
        check("en_rise_gnt", 32'(gnt), 32'h1);

        // Reset in the middle of a grant clears the pointer too
        do_reset();
        req = 4'b0100;
        step();
        step();
        check("mid_busy_idx", 32'(gnt_idx), 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_valid", 32'(gnt_valid), 32'd0);
        check("mid_rst_idx", 32'(gnt_idx), 32'd0);
        check("mid_rst_to", 32'(timeout), 32'd0);
        req = 4'b1111;
        step();
        check("ptr_reset_idx", 32'(gnt_idx), 32'd3);

        // Randomized run: fairness-checked first, then with en/reset noise
        do_reset();
        for (int i = 0; i < NR; i++) waitc[i] = 0;
        starve_on = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if (n == 6000) starve_on = 1'b0;
            if (n < 6000) begin
                en    = 1'b1;
                reset = 1'b0;
            end else begin
                en    = ($urandom_range(7, 0) != 0);
                reset = ($urandom_range(63, 0) == 0);
            end
            for (int b = 0; b < NR; b++) begin
                if ($urandom_range(7, 0) == 0) req[b] = ~req[b];
            end
            done = ($urandom_range(5, 0) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
